// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes, protection default and the
// control-initiator state set.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_EXOKAY  = 2'b01;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [1:0] RESP_DECERR  = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    typedef enum logic [5:0] {
        ST_IDLE   = 6'b000001,
        ST_WR_REQ = 6'b000010,
        ST_WR_RSP = 6'b000100,
        ST_RD_REQ = 6'b001000,
        ST_RD_RSP = 6'b010000,
        ST_RSP    = 6'b100000
    } state_t;

    // States in which the block is waiting on the peripheral and the hang timer runs.
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_WR_REQ) || (s == ST_WR_RSP) ||
               (s == ST_RD_REQ) || (s == ST_RD_RSP);
    endfunction

endpackage

// File: rtl/axil_ctrl_init_if.sv
// AXI4-Lite control bus between the initiator (master) and a register-mapped
// peripheral target (slave).
interface axil_ctrl_init_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic                  i_ctrl_awvalid;
    logic                  i_ctrl_awready;
    logic [ADDR_W-1:0]     i_ctrl_awaddr;
    logic [2:0]            i_ctrl_awprot;

    logic                  i_ctrl_wvalid;
    logic                  i_ctrl_wready;
    logic [DATA_W-1:0]     i_ctrl_wdata;
    logic [DATA_W/8-1:0]   i_ctrl_wstrb;

    logic                  i_ctrl_bvalid;
    logic                  i_ctrl_bready;
    logic [1:0]            i_ctrl_bresp;

    logic                  i_ctrl_arvalid;
    logic                  i_ctrl_arready;
    logic [ADDR_W-1:0]     i_ctrl_araddr;
    logic [2:0]            i_ctrl_arprot;

    logic                  i_ctrl_rvalid;
    logic                  i_ctrl_rready;
    logic [DATA_W-1:0]     i_ctrl_rdata;
    logic [1:0]            i_ctrl_rresp;

    modport master (
        output i_ctrl_awvalid, i_ctrl_awaddr, i_ctrl_awprot,
        input  i_ctrl_awready,
        output i_ctrl_wvalid, i_ctrl_wdata, i_ctrl_wstrb,
        input  i_ctrl_wready,
        input  i_ctrl_bvalid, i_ctrl_bresp,
        output i_ctrl_bready,
        output i_ctrl_arvalid, i_ctrl_araddr, i_ctrl_arprot,
        input  i_ctrl_arready,
        input  i_ctrl_rvalid, i_ctrl_rdata, i_ctrl_rresp,
        output i_ctrl_rready
    );

    modport slave (
        input  i_ctrl_awvalid, i_ctrl_awaddr, i_ctrl_awprot,
        output i_ctrl_awready,
        input  i_ctrl_wvalid, i_ctrl_wdata, i_ctrl_wstrb,
        output i_ctrl_wready,
        output i_ctrl_bvalid, i_ctrl_bresp,
        input  i_ctrl_bready,
        input  i_ctrl_arvalid, i_ctrl_araddr, i_ctrl_arprot,
        output i_ctrl_arready,
        output i_ctrl_rvalid, i_ctrl_rdata, i_ctrl_rresp,
        input  i_ctrl_rready
    );

endinterface

// File: rtl/axil_ctrl_init.sv
// AXI4-Lite initiator: turns one command into one AXI4-Lite read or write and
// hands back data and response; flags a sticky hang when the target stalls.
module axil_ctrl_init
    import axil_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,

    axil_ctrl_init_if.master    ctrl,

    output logic                busy,
    output logic                hang
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    state_t              state_r,    state_s;
    logic [ADDR_W-1:0]   addr_r,     addr_s;
    logic [DATA_W-1:0]   wdata_r,    wdata_s;
    logic [STRB_W-1:0]   wstrb_r,    wstrb_s;
    logic [DATA_W-1:0]   rdata_r,    rdata_s;
    logic [1:0]          resp_r,     resp_s;
    logic                aw_done_r,  aw_done_s;
    logic                w_done_r,   w_done_s;
    logic [CNT_W-1:0]    cnt_r,      cnt_s;
    logic                hang_r,     hang_s;
    logic                hang_base_s;
    logic                cmd_ready_r, cmd_ready_s;
    logic                awvalid_r,  awvalid_s;
    logic                wvalid_r,   wvalid_s;
    logic                bready_r,   bready_s;
    logic                arvalid_r,  arvalid_s;
    logic                rready_r,   rready_s;
    logic                rsp_valid_r, rsp_valid_s;
    logic                busy_r,     busy_s;

    // Next-state, datapath capture and per-channel completion tracking
    always_comb begin
        state_s     = state_r;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        wstrb_s     = wstrb_r;
        rdata_s     = rdata_r;
        resp_s      = resp_r;
        aw_done_s   = aw_done_r;
        w_done_s    = w_done_r;
        hang_base_s = hang_r;

        case (state_r)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_r) begin
                    addr_s      = cmd_addr;
                    wdata_s     = cmd_wdata;
                    wstrb_s     = cmd_wstrb;
                    aw_done_s   = 1'b0;
                    w_done_s    = 1'b0;
                    hang_base_s = 1'b0;
                    state_s     = cmd_write ? ST_WR_REQ : ST_RD_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                if (awvalid_r && ctrl.i_ctrl_awready) begin
                    aw_done_s = 1'b1;
                end else begin
                    aw_done_s = aw_done_r;
                end
                if (wvalid_r && ctrl.i_ctrl_wready) begin
                    w_done_s = 1'b1;
                end else begin
                    w_done_s = w_done_r;
                end
                if (aw_done_s && w_done_s) begin
                    state_s = ST_WR_RSP;
                end else begin
                    state_s = ST_WR_REQ;
                end
            end
            ST_WR_RSP: begin
                if (bready_r && ctrl.i_ctrl_bvalid) begin
                    resp_s  = ctrl.i_ctrl_bresp;
                    rdata_s = {DATA_W{1'b0}};
                    state_s = ST_RSP;
                end else begin
                    state_s = ST_WR_RSP;
                end
            end
            ST_RD_REQ: begin
                if (arvalid_r && ctrl.i_ctrl_arready) begin
                    state_s = ST_RD_RSP;
                end else begin
                    state_s = ST_RD_REQ;
                end
            end
            ST_RD_RSP: begin
                if (rready_r && ctrl.i_ctrl_rvalid) begin
                    rdata_s = ctrl.i_ctrl_rdata;
                    resp_s  = ctrl.i_ctrl_rresp;
                    state_s = ST_RSP;
                end else begin
                    state_s = ST_RD_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_valid_r && rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RSP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Hang timer: saturating dwell count per wait state, restarted on any state change
    always_comb begin
        cnt_s = cnt_r;
        if (state_s != state_r) begin
            cnt_s = {CNT_W{1'b0}};
        end else if (is_wait_state(state_r) && (cnt_r != CNT_MAX)) begin
            cnt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_s = cnt_r;
        end
        hang_s = hang_base_s || (cnt_s == CNT_MAX);
    end

    // Handshake outputs for the coming cycle, derived from the next state
    always_comb begin
        cmd_ready_s = (state_s == ST_IDLE);
        awvalid_s   = (state_s == ST_WR_REQ) && !aw_done_s;
        wvalid_s    = (state_s == ST_WR_REQ) && !w_done_s;
        bready_s    = (state_s == ST_WR_RSP);
        arvalid_s   = (state_s == ST_RD_REQ);
        rready_s    = (state_s == ST_RD_RSP);
        rsp_valid_s = (state_s == ST_RSP);
        busy_s      = (state_s != ST_IDLE);
    end

    // State, datapath and registered output flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
            wstrb_r     <= {STRB_W{1'b0}};
            rdata_r     <= {DATA_W{1'b0}};
            resp_r      <= RESP_OKAY;
            aw_done_r   <= 1'b0;
            w_done_r    <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            hang_r      <= 1'b0;
            cmd_ready_r <= 1'b0;
            awvalid_r   <= 1'b0;
            wvalid_r    <= 1'b0;
            bready_r    <= 1'b0;
            arvalid_r   <= 1'b0;
            rready_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            wstrb_r     <= wstrb_s;
            rdata_r     <= rdata_s;
            resp_r      <= resp_s;
            aw_done_r   <= aw_done_s;
            w_done_r    <= w_done_s;
            cnt_r       <= cnt_s;
            hang_r      <= hang_s;
            cmd_ready_r <= cmd_ready_s;
            awvalid_r   <= awvalid_s;
            wvalid_r    <= wvalid_s;
            bready_r    <= bready_s;
            arvalid_r   <= arvalid_s;
            rready_r    <= rready_s;
            rsp_valid_r <= rsp_valid_s;
            busy_r      <= busy_s;
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rdata_r;
    assign rsp_resp  = resp_r;
    assign busy      = busy_r;
    assign hang      = hang_r;

    assign ctrl.i_ctrl_awvalid = awvalid_r;
    assign ctrl.i_ctrl_awaddr  = addr_r;
    assign ctrl.i_ctrl_awprot  = PROT_DEFAULT;
    assign ctrl.i_ctrl_wvalid  = wvalid_r;
    assign ctrl.i_ctrl_wdata   = wdata_r;
    assign ctrl.i_ctrl_wstrb   = wstrb_r;
    assign ctrl.i_ctrl_bready  = bready_r;
    assign ctrl.i_ctrl_arvalid = arvalid_r;
    assign ctrl.i_ctrl_araddr  = addr_r;
    assign ctrl.i_ctrl_arprot  = PROT_DEFAULT;
    assign ctrl.i_ctrl_rready  = rready_r;

endmodule

// File: doc/axil_ctrl_init.md
Name: axil_ctrl_init

Overview:
- AXI4-Lite initiator (manager) that drives the control port of register-mapped peripherals such as the GPIO/capture control block.
- Accepts single read or write commands on a simple valid/ready command port and runs exactly one AXI4-Lite transaction per command.
- Returns the read data and response code on a valid/ready response port.
- Sits between a local sequencer or CPU-side bridge and the peripheral `t_ctrl_*` target ports; one transaction is outstanding at a time.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width; must be 32 or 64.
- TIMEOUT_CYC, 1024, cycles in a wait state before the `hang` flag is raised; must be ≥ 2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data
- cmd_wstrb  in  DATA_W/8  write strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_resp  out  2  AXI response code
- i_ctrl_awvalid  out  1 / i_ctrl_awready  in  1 / i_ctrl_awaddr  out  ADDR_W / i_ctrl_awprot  out  3
- i_ctrl_wvalid  out  1 / i_ctrl_wready  in  1 / i_ctrl_wdata  out  DATA_W / i_ctrl_wstrb  out  DATA_W/8
- i_ctrl_bvalid  in  1 / i_ctrl_bready  out  1 / i_ctrl_bresp  in  2
- i_ctrl_arvalid  out  1 / i_ctrl_arready  in  1 / i_ctrl_araddr  out  ADDR_W / i_ctrl_arprot  out  3
- i_ctrl_rvalid  in  1 / i_ctrl_rready  out  1 / i_ctrl_rdata  in  DATA_W / i_ctrl_rresp  in  2
- busy  out  1  high in any state other than IDLE
- hang  out  1  sticky timeout flag

Behaviour:
- Clock and reset: single clock `clk`; `reset` is asynchronous, active-high.
- Reset values: all valid/ready outputs 0, `hang` 0, data, address and response registers 0, state IDLE.
- Reset mid-transaction aborts immediately. The peripheral must be reset together with this block.
- FSM states: IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, RSP. Encodings are one-hot.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, register addr, wdata and wstrb, and clear `hang`.
  - Go to WR_REQ if cmd_write, else RD_REQ.
- WR_REQ:
  - awvalid and wvalid both rise in the cycle after command accept.
  - Each channel independently drops in the cycle after its own valid&ready.
  - Accept order may be AW first, W first, or both in the same cycle; track completion with one done bit per channel.
  - When both channels are done, go to WR_RSP; bready = 1 in the same cycle as the transition.
  - valid is never withdrawn before ready, and payload is held stable while valid.
- WR_RSP:
  - bready = 1.
  - On bvalid, capture bresp into rsp_resp, set rsp_rdata = 0, drop bready, and go to RSP.
- RD_REQ:
  - arvalid = 1 until arready, then go to RD_RSP.
- RD_RSP:
  - rready = 1.
  - On rvalid, capture rdata and rresp, and go to RSP.
- RSP:
  - rsp_valid = 1, with data and resp stable.
  - On rsp_ready, go to IDLE; cmd_ready reasserts in that next cycle.
- awprot and arprot are fixed at 3'b000. Addresses pass through unmodified.
- Minimum latency, with cmd accepted at cycle 0 and a zero-wait target:
  - Write: aw/wvalid at cycle 1, bvalid at cycle 2, rsp_valid at cycle 3.
  - Read: arvalid at cycle 1, rvalid at cycle 2, rsp_valid at cycle 3.
- Throughput: one command per 4 cycles at best.
- Timeout:
  - A saturating counter counts cycles spent in WR_REQ, WR_RSP, RD_REQ and RD_RSP; it is cleared on every state change.
  - When the counter reaches TIMEOUT_CYC, `hang` sets and stays set until the next command accept.
  - The transaction is NOT abandoned; the block keeps waiting, because AXI gives it no legal way to withdraw.
- Error responses (SLVERR, DECERR) are passed through without retry.

Decomposition:
- Shared package `axil_pkg`:
  - Response codes: RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11.
  - State enum for this block.
  - PROT_DEFAULT = 3'b000.
- No sub-module: the FSM, per-channel done bits and timeout counter all live in one module.

Test Plan:
- Write addr 0x0, data 0x15, wstrb 0xF; target awready and wready both high in cycle 1 → bready at cycle 2; bresp OKAY → rsp_valid at cycle 3, rsp_resp 0, rsp_rdata 0; the target's odata becomes 0x15.
- Write addr 0x4; target raises wready at cycle 1 and awready at cycle 3 → wvalid drops at cycle 2, awvalid drops at cycle 4, bready rises at cycle 4, awaddr stays 0x4 throughout.
- Read addr 0x4 after writing oenable 0x2A → araddr 0x4, rsp_rdata 0x0000002A, rsp_resp OKAY.
- Hold rsp_ready low for 5 cycles in RSP → rsp_valid and rsp_rdata stay stable and cmd_ready stays 0; cmd_ready returns 1 the cycle after rsp_ready.
- Target never asserts awready, with TIMEOUT_CYC = 8 → `hang` = 1 after 8 cycles in WR_REQ and awvalid stays 1; then assert reset → all outputs 0 and state IDLE.
- Target returns rresp = 2'b10 → rsp_resp = 2'b10; the next command is accepted normally and clears `hang`.
